// File: rtl/vending_pkg.sv
// Shared constants and types for the 15-cent coin-accepting vending controller.
package vending_pkg;

  localparam logic [3:0] PRICE_N = 4'd3;
  localparam logic [3:0] N_VAL   = 4'd1;
  localparam logic [3:0] D_VAL   = 4'd2;
  localparam logic [3:0] Q_VAL   = 4'd5;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [1:0] Z_IDLE     = 2'b00;
  localparam logic [1:0] Z_DISPENSE = 2'b01;
  localparam logic [1:0] Z_NICKEL   = 2'b10;

endpackage

// File: rtl/vending_machine.sv
// Vending FSM: sums coin deposits in nickel units, dispenses at 15 cents and
// returns any excess as back-to-back single-nickel pulses on z.
module vending_machine
  import vending_pkg::*;
(
  output logic [1:0] z,
  input  logic       reset,
  input  logic       clk,
  input  logic       n,
  input  logic       d,
  input  logic       q,
  input  logic       D
);

  state_t     r_state;
  logic [1:0] r_credit;
  logic [2:0] r_change;
  logic [1:0] r_z;

  state_t     w_state_next;
  logic [1:0] w_credit_next;
  logic [2:0] w_change_next;
  logic [1:0] w_z_next;
  logic [3:0] w_total;
  logic       w_coin;

  // Credit never exceeds 2, so the widest total is 2+1+2+5 = 10.
  assign w_total = {2'b00, r_credit}
                 + (n ? N_VAL : 4'd0)
                 + (d ? D_VAL : 4'd0)
                 + (q ? Q_VAL : 4'd0);
  assign w_coin  = n | d | q;

  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_change_next = r_change;
    w_z_next      = Z_IDLE;
    case (r_state)
      ACCEPT: begin
        if (D && w_coin) begin
          if (w_total < PRICE_N) begin
            w_credit_next = w_total[1:0];
          end else begin
            w_credit_next = 2'd0;
            w_change_next = 3'(w_total - PRICE_N);
            w_state_next  = VEND;
            w_z_next      = Z_DISPENSE;
          end
        end
      end
      // Both busy states behave alike: coins are dropped, change drains.
      VEND, CHANGE: begin
        if (r_change != 3'd0) begin
          w_state_next  = CHANGE;
          w_change_next = r_change - 3'd1;
          w_z_next      = Z_NICKEL;
        end else begin
          w_state_next  = ACCEPT;
        end
      end
      default: begin
        w_state_next = ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ACCEPT;
      r_credit <= 2'd0;
      r_change <= 3'd0;
      r_z      <= Z_IDLE;
    end else begin
      r_state  <= w_state_next;
      r_credit <= w_credit_next;
      r_change <= w_change_next;
      r_z      <= w_z_next;
    end
  end

  assign z = r_z;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench: a queue-based reference model checked every cycle,
// plus directed sequences with literal expected action codes.
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       n = 1'b0;
  logic       d = 1'b0;
  logic       q = 1'b0;
  logic       D = 1'b0;
  logic [1:0] z;

  int tests = 0;
  int fails = 0;

  // Reference model: credit in cents and a queue of outputs still owed
  // by a vend in progress (nickels, then one idle cycle before accepting).
  int         m_credit = 0;
  logic [1:0] m_pending[$];
  logic [1:0] m_z = 2'b00;
  bit         m_valid = 1'b0;

  vending_machine dut (
    .z     (z),
    .reset (reset),
    .clk   (clk),
    .n     (n),
    .d     (d),
    .q     (q),
    .D     (D)
  );

  always #5 clk = ~clk;

  initial begin
    int cents;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pending.delete();
        m_credit = 0;
        m_z      = 2'b00;
        m_valid  = 1'b1;
      end else if (m_pending.size() > 0) begin
        m_z = m_pending.pop_front();
      end else if (D && (n || d || q)) begin
        cents = m_credit + (n ? 5 : 0) + (d ? 10 : 0) + (q ? 25 : 0);
        if (cents < 15) begin
          m_credit = cents;
          m_z      = 2'b00;
        end else begin
          m_credit = 0;
          m_z      = 2'b01;
          for (int i = 0; i < (cents - 15) / 5; i++) m_pending.push_back(2'b10);
          m_pending.push_back(2'b00);
        end
      end else begin
        m_z = 2'b00;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        tests++;
        if (z !== m_z) begin
          fails++;
          $display("FAIL model_cmp t=%0t: z=%b expected %b", $time, z, m_z);
        end
      end
    end
  end

  task automatic cyc(input logic rst_i, input logic n_i, input logic d_i,
                     input logic q_i, input logic dep_i);
    @(negedge clk);
    reset = rst_i;
    n     = n_i;
    d     = d_i;
    q     = q_i;
    D     = dep_i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [1:0] exp_z, input string name);
    tests++;
    if (z !== exp_z) begin
      fails++;
      $display("FAIL %s: z=%b expected %b", name, z, exp_z);
    end else begin
      $display("[TB] %s: z=%b ok", name, z);
    end
  endtask

  task automatic idle_chk(input logic [1:0] exp_z, input string name);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk(exp_z, name);
  endtask

  initial begin
    // Reset held, then one nickel.
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk(2'b00, "reset_idle");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); chk(2'b00, "nickel_credit");
    idle_chk(2'b00, "nickel_hold1");
    idle_chk(2'b00, "nickel_hold2");

    // Nickel then dime: single dispense, then idle.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); chk(2'b01, "n_d_dispense");
    idle_chk(2'b00, "n_d_after");

    // Strobe with no coin and coins without strobe add nothing.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); chk(2'b00, "strobe_nocoin");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0); chk(2'b00, "coins_nostrobe");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); chk(2'b00, "dime_from_zero");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); chk(2'b01, "dime_nickel_vend");
    idle_chk(2'b00, "dime_nickel_after");

    // Quarter on zero credit: 01, 10, 10, 00.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); chk(2'b01, "q_dispense");
    idle_chk(2'b10, "q_change1");
    idle_chk(2'b10, "q_change2");
    idle_chk(2'b00, "q_done");

    // Simultaneous nickel and dime sum to exactly the price.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); chk(2'b01, "nd_dispense");
    idle_chk(2'b00, "nd_no_change");

    // Dime, then nickel+quarter: 40 cents, five nickels back.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); chk(2'b00, "pre_dime");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1); chk(2'b01, "nq_dispense");
    idle_chk(2'b10, "nq_change1");
    idle_chk(2'b10, "nq_change2");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); chk(2'b10, "nq_change3_busy_dime");
    idle_chk(2'b10, "nq_change4");
    idle_chk(2'b10, "nq_change5");
    idle_chk(2'b00, "nq_done");
    // Discarded dime must not have left credit: one dime stays idle.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); chk(2'b00, "busy_dime_lost");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); chk(2'b01, "busy_dime_lost_vend");
    idle_chk(2'b00, "busy_dime_after");

    // Worst case: all three coins on 10 cents, seven nickels.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); chk(2'b00, "wc_pre_dime");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1); chk(2'b01, "wc_dispense");
    for (int i = 1; i <= 7; i++) idle_chk(2'b10, $sformatf("wc_change%0d", i));
    idle_chk(2'b00, "wc_done");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); chk(2'b00, "wc_accept_n1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); chk(2'b00, "wc_accept_n2");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); chk(2'b01, "wc_accept_n3");
    idle_chk(2'b00, "wc_accept_after");

    // Reset mid change return forfeits the remaining nickel.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); chk(2'b01, "rst_q_dispense");
    idle_chk(2'b10, "rst_q_change1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); chk(2'b00, "rst_abort");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); chk(2'b00, "rst_then_nickel");
    idle_chk(2'b00, "rst_no_leftover1");
    idle_chk(2'b00, "rst_no_leftover2");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); chk(2'b01, "rst_nickel_dime_vend");
    idle_chk(2'b00, "rst_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
